// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data memory controller.
package data_mem_pkg;

  localparam int CNT_W       = 4;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/data_mem_array.sv
// Word storage: 2^ADDR_W x 32 with one synchronous write port and one registered read port.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  input  logic              rd_zero,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // The read register is the load result seen by the pipeline; it holds between loads.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= rd_zero ? '0 : mem[rd_idx];
  end

endmodule

// File: rtl/data_mem.sv
// Multi-cycle data memory with request latching and pipeline stall.
// Optional build macro DATA_MEM_MISALIGN_TRAP_EN traps accesses with addr[1:0] != 0.
//
//   state | meaning
//   IDLE  | waiting; a request is latched when data_mem_read_enable is high
//   BUSY  | counting down LATENCY cycles; access happens when the counter hits 0
//   DONE  | one-cycle completion; stall released, result valid
module data_mem
  import data_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_mem_read_enable,
  input  logic        data_mem_write_enable,
  input  logic [31:0] data_mem_read_addr,
  input  logic [31:0] data_mem_write_addr,
  input  logic [31:0] data_mem_write_data,
  output logic [31:0] data_mem_read_data,
  output logic        data_mem_stall,
  output logic        data_mem_misalign_err
);

  localparam cnt_t CNT_INIT = cnt_t'(LATENCY - 1);

  state_t            state;
  cnt_t              cnt;
  logic              store_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              fire;
  logic              misalign;
  logic [ADDR_W-1:0] word_idx;
  logic              unused_addr_bits;

  assign word_idx = addr_q[ADDR_W+1:2];
  // High bits alias; low bits only matter to the trap build.
  assign unused_addr_bits = ^{addr_q[31:ADDR_W+2], addr_q[1:0]};

  // The access edge; gated by rst so a reset in the last BUSY cycle writes nothing.
  assign fire = (state == BUSY) && (cnt == '0) && !rst;

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  assign misalign = (addr_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (data_mem_read_enable) begin
            state   <= BUSY;
            cnt     <= CNT_INIT;
            store_q <= data_mem_write_enable;
            addr_q  <= data_mem_write_enable ? data_mem_write_addr : data_mem_read_addr;
            wdata_q <= data_mem_write_data;
          end
        end
        BUSY: begin
          if (cnt != '0) cnt <= cnt - cnt_t'(1);
          else           state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign data_mem_stall = data_mem_read_enable && (state != DONE);

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= fire && misalign;
  end

  assign data_mem_misalign_err = err_q;
`else
  assign data_mem_misalign_err = 1'b0;
`endif

  data_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fire && store_q && !misalign),
    .wr_idx  (word_idx),
    .wr_data (wdata_q),
    .rd_en   (fire && !store_q),
    .rd_zero (misalign),
    .rd_idx  (word_idx),
    .rd_data (data_mem_read_data)
  );

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: instance 0 runs LATENCY=2, instance 1 runs LATENCY=1.
module tb_data_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        re    [2];
  logic        we    [2];
  logic [31:0] ra    [2];
  logic [31:0] wa    [2];
  logic [31:0] wd    [2];
  logic [31:0] rd    [2];
  logic        stall [2];
  logic        err   [2];
  int          lat   [2] = '{2, 1};

  data_mem #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk(clk), .rst(rst[0]),
    .data_mem_read_enable(re[0]), .data_mem_write_enable(we[0]),
    .data_mem_read_addr(ra[0]), .data_mem_write_addr(wa[0]),
    .data_mem_write_data(wd[0]), .data_mem_read_data(rd[0]),
    .data_mem_stall(stall[0]), .data_mem_misalign_err(err[0])
  );

  data_mem #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst[1]),
    .data_mem_read_enable(re[1]), .data_mem_write_enable(we[1]),
    .data_mem_read_addr(ra[1]), .data_mem_write_addr(wa[1]),
    .data_mem_write_data(wd[1]), .data_mem_read_data(rd[1]),
    .data_mem_stall(stall[1]), .data_mem_misalign_err(err[1])
  );

  // Reference model: a plain word array per instance, indexed modulo the memory size.
  logic [31:0] ref_mem [2][1024];
  bit          known   [2][1024];
  logic [31:0] last_rd [2];
  bit          rd_known[2];

  typedef struct {
    logic [31:0] data;
    bit          chk;
    bit          err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  function automatic bit trap(input logic [31:0] a);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'd1024);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_issue(input int s, input bit st, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   i;
    i     = widx(a);
    e.err = trap(a);
    if (st) begin
      if (!e.err) begin
        ref_mem[s][i] = d;
        known[s][i]   = 1'b1;
      end
      e.data = last_rd[s];
      e.chk  = rd_known[s];
    end else begin
      e.data      = e.err ? 32'h0 : ref_mem[s][i];
      e.chk       = e.err || known[s][i];
      last_rd[s]  = e.data;
      rd_known[s] = e.chk;
    end
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: a completion is the one cycle where a request is up but stall is down.
  always @(negedge clk) begin
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      if (rst[s] === 1'b1) continue;
      if (re[s] === 1'b1 && stall[s] === 1'b0) begin
        if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected dut%0d: got completion expected none", s);
        end else begin
          if (s == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          if (e.chk) check($sformatf("read_data dut%0d", s), rd[s], e.data);
          check($sformatf("misalign_err_done dut%0d", s), {31'b0, err[s]}, {31'b0, e.err});
        end
      end else begin
        check($sformatf("misalign_err_quiet dut%0d", s), {31'b0, err[s]}, 32'h0);
      end
    end
  end

  task automatic access(input int s, input bit st, input logic [31:0] a, input logic [31:0] d,
                        input bit scramble, input bit keep);
    int n;
    n = 0;
    @(posedge clk); #1;
    re[s] = 1'b1;
    we[s] = st;
    wd[s] = d;
    if (st) begin wa[s] = a; ra[s] = $urandom; end
    else    begin ra[s] = a; wa[s] = $urandom; end
    model_issue(s, st, a, d);
    forever begin
      @(negedge clk);
      if (stall[s] !== 1'b1) break;
      n++;
      if (n > 40) begin
        checks++;
        errors++;
        $display("FAIL stall_timeout dut%0d: got stall stuck expected release", s);
        keep = 1'b0;
        break;
      end
      // Only scramble once the request has been latched (n >= 2 means inside BUSY).
      if (scramble && n >= 2) begin
        we[s] = 1'($urandom);
        ra[s] = $urandom;
        wa[s] = $urandom;
        wd[s] = $urandom;
      end
    end
    check($sformatf("stall_cycles dut%0d", s), 32'(n), 32'(lat[s] + 1));
    if (!keep) begin
      @(posedge clk); #1;
      re[s] = 1'b0;
    end
  endtask

  task automatic drop_req(input int s);
    @(posedge clk); #1;
    re[s] = 1'b0;
  endtask

  task automatic random_phase(input int s, input int nops);
    logic [31:0] a;
    for (int w = 0; w < 16; w++) access(s, 1'b1, 32'h200 + 32'(w * 4), $urandom, 1'b0, 1'b0);
    for (int k = 0; k < nops; k++) begin
      a = 32'h200 + 32'($urandom_range(0, 15) * 4);
      a[31:12] = 20'($urandom);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      access(s, 1'($urandom_range(0, 1)), a, $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drop_req(s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; re[s] = 1'b0; we[s] = 1'b0;
      ra[s] = '0; wa[s] = '0; wd[s] = '0;
      last_rd[s] = '0; rd_known[s] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset_read_data dut%0d", s), rd[s], 32'h0);
      check($sformatf("reset_stall dut%0d", s), {31'b0, stall[s]}, 32'h0);
      check($sformatf("reset_err dut%0d", s), {31'b0, err[s]}, 32'h0);
    end

    // Basic store/load round trip
    access(0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0);
    access(0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0);

    // Aliasing: 0x1000 maps onto word 0
    access(0, 1'b1, 32'h0, 32'h11, 1'b0, 1'b0);
    access(0, 1'b0, 32'h1000, 32'h0, 1'b0, 1'b0);

    // Back-to-back loads with the request held high
    access(0, 1'b1, 32'h20, 32'h5, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) access(0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1);
    drop_req(0);

    // Reset in the last BUSY cycle of a store aborts it
    access(0, 1'b1, 32'h40, 32'hAA, 1'b0, 1'b0);
    @(posedge clk); #1;
    re[0] = 1'b1; we[0] = 1'b1; wa[0] = 32'h40; wd[0] = 32'hBB; ra[0] = 32'h0;
    @(posedge clk);
    @(posedge clk); #1;
    rst[0] = 1'b1;
    re[0]  = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    last_rd[0]  = 32'h0;
    rd_known[0] = 1'b1;
    @(negedge clk);
    check("abort_read_data_cleared", rd[0], 32'h0);
    check("abort_stall_low", {31'b0, stall[0]}, 32'h0);
    access(0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);

    // Misaligned store; outcome depends on the trap build
    access(0, 1'b1, 32'h42, 32'h77, 1'b0, 1'b0);
    access(0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);

    random_phase(0, 40);

    // LATENCY=1 instance, with inputs scrambled mid-access
    access(1, 1'b1, 32'h80, 32'h12345678, 1'b1, 1'b0);
    access(1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0);
    access(1, 1'b1, 32'h84, 32'hCAFEF00D, 1'b0, 1'b0);
    access(1, 1'b0, 32'h84, 32'h0, 1'b1, 1'b0);
    random_phase(1, 40);

    t = 0;
    while ((q0.size() + q1.size()) != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, word-index width (memory holds 2^ADDR_W 32-bit words).
REQ-002 The block SHALL have parameter LATENCY, default 2, legal range 1..15, busy cycles per access.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 The block SHALL have port data_mem_read_enable  input  1  access request; high for both loads and stores.
REQ-006 The block SHALL have port data_mem_write_enable  input  1  qualifies the request as a store.
REQ-007 The block SHALL have port data_mem_read_addr  input  32  byte address for loads.
REQ-008 The block SHALL have port data_mem_write_addr  input  32  byte address for stores.
REQ-009 The block SHALL have port data_mem_write_data  input  32  store data.
REQ-010 The block SHALL have port data_mem_read_data  output  32  load result, registered.
REQ-011 The block SHALL have port data_mem_stall  output  1  pipeline freeze request.
REQ-012 The block SHALL have port data_mem_misalign_err  output  1  one-cycle misaligned-access flag.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-014 In IDLE with data_mem_read_enable=1, the block SHALL accept the request and latch the store flag, the address (write_addr if store, else read_addr) and the write data; next state BUSY, counter=LATENCY-1.
REQ-015 In BUSY with counter!=0, the counter SHALL decrement; with counter==0, the access SHALL be performed using latched values and the next state SHALL be DONE.
REQ-016 The access SHALL be: a store writes the array word; a load loads data_mem_read_data from the array word; a store leaves data_mem_read_data unchanged.
REQ-017 In DONE the next state SHALL be IDLE unconditionally; a new request is accepted only in IDLE.
REQ-018 data_mem_stall SHALL equal data_mem_read_enable AND (state!=DONE), combinationally; the stall therefore lasts exactly LATENCY+1 cycles per access.
REQ-019 The word index SHALL be addr[ADDR_W+1:2]; higher address bits SHALL be ignored (aliasing wrap-around).
REQ-020 data_mem_read_data SHALL hold its value until the next completed load.
REQ-021 A change of the request inputs during BUSY SHALL have no effect; the latched values govern the access.
REQ-022 data_mem_read_enable dropping during BUSY SHALL NOT abort the access.

Reset
REQ-023 Reset SHALL force state=IDLE, counter=0, data_mem_read_data=0 and data_mem_misalign_err=0; data_mem_stall then follows REQ-018.
REQ-024 Reset during BUSY SHALL abort the access; no array write SHALL occur on that edge or later.
REQ-025 Array contents SHALL NOT be reset.

Configuration
REQ-026 With DATA_MEM_MISALIGN_TRAP_EN defined, a latched address with addr[1:0]!=0 SHALL suppress the store, or load 0 for a load, and SHALL assert data_mem_misalign_err for exactly the DONE cycle.
REQ-027 Without DATA_MEM_MISALIGN_TRAP_EN, addr[1:0] SHALL be ignored and data_mem_misalign_err SHALL be constant 0; the port SHALL exist in both builds.

Structure
REQ-028 Package data_mem_pkg SHALL hold the FSM state type (IDLE/BUSY/DONE), the LATENCY counter width (4) and the default parameter values.
REQ-029 Storage SHALL be in sub-module data_mem_array: 2^ADDR_W x 32, one synchronous write port and one synchronous read port; the FSM and latches stay in data_mem.

Verification
REQ-030 The bench SHALL check: LATENCY=2; store 0xDEADBEEF to 0x100, then load 0x100 -> stall high 3 cycles per access, read_data=0xDEADBEEF in the load DONE cycle.
REQ-031 The bench SHALL check: ADDR_W=10; store 0x11 to 0x0, load 0x1000 -> read_data=0x11 (alias).
REQ-032 The bench SHALL check: store 0x5 to 0x20; hold read_enable=1, write_enable=0, addr 0x20 continuously -> back-to-back loads, each DONE followed by IDLE with stall re-asserted, each returning 0x5.
REQ-033 The bench SHALL check: store 0xAA to 0x40, then issue store 0xBB to 0x40 and assert rst during BUSY -> subsequent load of 0x40 returns 0xAA, read_data=0 right after reset.
REQ-034 The bench SHALL check: with the macro defined, store 0x77 to 0x42 -> misalign_err=1 for one cycle and word 0x40 unchanged; without the macro, same store -> err=0 and word 0x40=0x77.
REQ-035 The bench SHALL check: LATENCY=1 -> stall exactly 2 cycles per access; changing addr/data mid-BUSY has no effect on the result.
